// File: rtl/mmio_uart_tx_responder.sv
// Memory-mapped UART transmitter: 16-byte register window, byte TX FIFO, 8N1 serialiser.
// Latency: reads are combinational; a push into an empty idle FIFO pops one edge later and the start bit follows that edge.
// Backpressure: none on the bus; a push into a full FIFO is discarded and counted in DROPPED (saturating).
module mmio_uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Hit_o,
  output logic        Tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          enable_q, enable_d;
  logic [7:0]    dropped_q, dropped_d;

  logic          full, empty;
  logic          wr_txdata, wr_ctrl, wr_dropped;
  logic          push, pop, overflow;
  logic [31:0]   count_ext;
  logic [31:0]   status;
  logic          unused_bits;

  assign Hit_o      = (Address_i[31:4] == BASE_ADDR[31:4]);
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign count_ext  = 32'(count_q);
  assign status     = {26'd0, count_ext[2:0], empty, full, (state_q != IDLE)};

  // Byte-lane selects and unused upper count bits are intentionally ignored.
  assign unused_bits = ^{Address_i[1:0], Write_Data_i[31:8], count_ext[31:3]};

  assign wr_txdata  = Hit_o && Mem_Write_i && (Address_i[3:2] == 2'd0);
  assign wr_ctrl    = Hit_o && Mem_Write_i && (Address_i[3:2] == 2'd2);
  assign wr_dropped = Hit_o && Mem_Write_i && (Address_i[3:2] == 2'd3);
  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign push       = wr_txdata && !full;
  assign overflow   = wr_txdata && full;

  // Zero-latency register read mux; drives zero unless this is a load that hits the window.
  always_comb begin
    Read_Data_o = 32'h0;
    if (Hit_o && Mem_Read_i) begin
      case (Address_i[3:2])
        2'd0:    Read_Data_o = 32'h0;
        2'd1:    Read_Data_o = status;
        2'd2:    Read_Data_o = {31'd0, enable_q};
        default: Read_Data_o = {24'd0, dropped_q};
      endcase
    end
  end

  // Next-state for control, drop counter and FIFO occupancy.
  always_comb begin
    enable_d  = wr_ctrl ? Write_Data_i[0] : enable_q;
    dropped_d = dropped_q;
    if (wr_dropped) begin
      dropped_d = 8'd0;
    end else if (overflow && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serialiser FSM: next state, bit timing, shift register and line level.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    Tx_o      = 1'b1;
    case (state_q)
      IDLE: begin
        if (enable_q && !empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        Tx_o = 1'b0;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      DATA: begin
        Tx_o = shift_q[0];
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      enable_q  <= 1'b1;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      enable_q  <= enable_d;
      dropped_q <= dropped_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage has no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= Write_Data_i[7:0];
  end

endmodule
